branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Direct-mapped branch predictor with BTB. It sits at the other end of the
//  branch-resolution path from the EX-stage compare unit.
//  - IF side: looks up if_pc and returns the predicted direction and target.
//  - EX side: takes the resolved outcome (takeBranch) and target, trains the
//    tables, and raises mispredict/redirect_pc so the pipeline can flush.
// PARAMETERS
//  IDX_BITS  6   table index width; depth = 2**IDX_BITS entries
//  TAG_BITS  8   stored tag width, taken from pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]
//  CNT_W     32  width of the performance counters
// PORTS
//  clk             in   1         rising-edge clock
//  rst             in   1         synchronous reset, active-high
//  if_pc           in   32        fetch PC to predict
//  pred_taken      out  1         prediction: taken
//  pred_target     out  32        predicted target (valid when pred_taken=1)
//  ex_valid        in   1         EX stage holds a real (non-bubble) instruction
//  ex_is_branch    in   1         EX instruction is a conditional branch (op 1100011)
//  ex_pc           in   32        PC of the EX instruction
//  ex_taken        in   1         resolved direction from the compare unit
//  ex_target       in   32        resolved branch target (pc + imm)
//  ex_pred_taken   in   1         pred_taken, pipelined with the instruction
//  ex_pred_target  in   32        pred_target, pipelined with the instruction
//  mispredict      out  1         flush IF/ID and redirect fetch
//  redirect_pc     out  32        correct next PC when mispredict=1
//  branch_cnt      out  CNT_W     number of resolved branches
//  mispred_cnt     out  CNT_W     number of mispredicted branches
// BEHAVIOUR
//  Per entry: valid(1), tag(TAG_BITS), ctr(2, saturating), target(32).
//  idx = pc[IDX_BITS+1:2], tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]; pc[1:0] ignored.
//  Reset (rst=1 at posedge):
//  - every valid=0 and every ctr=2'b01
//  - branch_cnt=0, mispred_cnt=0; tags and targets are don't-care
//  - the combinational outputs follow from this state: pred_taken=0, and with
//    no EX branch, mispredict=0.
//  Lookup (combinational, zero latency):
//  - hit = valid[idx] && tag[idx]==tag(if_pc)
//  - pred_taken = hit && ctr[1]; pred_target = hit ? target[idx] : 32'h0
//  Resolve (combinational): upd = ex_valid && ex_is_branch
//  - mispredict = upd && ((ex_taken != ex_pred_taken) ||
//    (ex_taken && ex_pred_target != ex_target))
//  - redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4 (mod 2^32)
//  - outputs are valid whenever upd=1, else mispredict=0.
//  Update (at posedge when upd=1 and rst=0), entry chosen by ex_pc:
//  - taken, EX hit: ctr = min(ctr+1, 3); target = ex_target
//  - taken, EX miss: allocate/replace; valid=1, tag=tag(ex_pc), ctr=2'b10,
//    target=ex_target
//  - not taken, EX hit: ctr = max(ctr-1, 0); valid unchanged
//  - not taken, EX miss: no table change
//  - branch_cnt += 1; mispred_cnt += mispredict
//  - both counters saturate at all-ones and never wrap.
//  Simultaneous same-index lookup and update: lookup returns the pre-update
//  value (no bypass); the new value is visible from the next cycle.
//  ex_valid=0 or ex_is_branch=0: no state change, mispredict=0.
//  rst in the same cycle as upd: reset wins and the update is discarded.
// TESTING
//  1 After reset, if_pc=0x100 -> pred_taken=0, pred_target=0;
//    branch_cnt=0, mispred_cnt=0.
//  2 Branch at 0x100 resolved taken to 0x80 with ex_pred_taken=0
//    -> mispredict=1, redirect_pc=0x80.
//    Next cycle, if_pc=0x100 -> pred_taken=1, pred_target=0x80;
//    mispred_cnt=1, branch_cnt=1.
//  3 Four more taken resolves of 0x100 -> ctr saturates at 3.
//    Then 2 not-taken -> ctr=1 and pred_taken=0;
//    redirect_pc=0x104 on each not-taken mispredict.
//  4 Alias: 0x100 and 0x100+(4<<IDX_BITS) map to the same idx, different tag.
//    A taken resolve of the alias replaces the entry -> lookup of 0x100 misses.
//  5 Same-cycle update and lookup of 0x200 (first taken) -> pred_taken=0 in
//    that cycle and 1 in the next; assert rst together with upd -> table and
//    counters are reset.
//  6 ex_valid=0 with ex_is_branch=1 and ex_taken=1 -> mispredict=0 and no
//    change to the tables or counters.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: 2-bit saturating direction counters plus a
// tagged BTB, looked up combinationally from IF and trained from resolved EX branches.
module branch_predictor #(
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 8,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       if_pc,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic [31:0]       ex_pc,
    input  logic              ex_taken,
    input  logic [31:0]       ex_target,
    input  logic              ex_pred_taken,
    input  logic [31:0]       ex_pred_target,
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);

    localparam int DEPTH = 1 << IDX_BITS;

    logic [DEPTH-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q    [DEPTH];
    logic [1:0]          ctr_q    [DEPTH];
    logic [31:0]         target_q [DEPTH];
    logic [CNT_W-1:0]    branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]    mispred_cnt_q, mispred_cnt_d;
    logic [1:0]          ctr_d;

    logic [IDX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_BITS-1:0] if_tag, ex_tag;
    logic                if_hit, ex_hit, upd;
    logic [1:0]          ex_ctr;

    // Address bits outside the index/tag fields do not take part in the lookup.
    logic unused_if_pc_bits;
    assign unused_if_pc_bits = ^{if_pc[1:0], if_pc[31:IDX_BITS+TAG_BITS+2]};

    assign if_idx = if_pc[IDX_BITS+1:2];
    assign if_tag = if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign ex_idx = ex_pc[IDX_BITS+1:2];
    assign ex_tag = ex_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

    // Lookup reads only registered state, so a same-cycle update is not bypassed.
    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = if_hit && ctr_q[if_idx][1];
    assign pred_target = if_hit ? target_q[if_idx] : 32'h0;

    assign upd         = ex_valid && ex_is_branch;
    assign ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign ex_ctr      = ctr_q[ex_idx];
    assign mispredict  = upd && ((ex_taken != ex_pred_taken) ||
                                 (ex_taken && (ex_pred_target != ex_target)));
    assign redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;

    always_comb begin
        ctr_d = ex_ctr;
        if (ex_taken) begin
            if (!ex_hit)
                ctr_d = 2'b10;
            else if (ex_ctr != 2'b11)
                ctr_d = ex_ctr + 2'd1;
        end else if (ex_hit && (ex_ctr != 2'b00)) begin
            ctr_d = ex_ctr - 2'd1;
        end
    end

    // Performance counters stick at all-ones instead of wrapping.
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd && !(&branch_cnt_q))
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        if (mispredict && !(&mispred_cnt_q))
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                ctr_q[i] <= 2'b01;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            if (upd) begin
                ctr_q[ex_idx] <= ctr_d;
                if (ex_taken)
                    valid_q[ex_idx] <= 1'b1;
            end
        end
    end

    // Tags and targets carry no reset; they are meaningful only while valid.
    always_ff @(posedge clk) begin
        if (!rst && upd && ex_taken) begin
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= ex_target;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus random traffic checked
// against a behavioural table model through an expected-value queue.
module tb_branch_predictor;

    localparam int IDX_BITS = 6;
    localparam int TAG_BITS = 8;
    localparam int CNT_W    = 32;
    localparam int DEPTH    = 1 << IDX_BITS;
    localparam int W        = 1 + 32 + 1 + 32 + 2 * CNT_W;

    logic             clk;
    logic             rst;
    logic [31:0]      if_pc;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic             ex_valid;
    logic             ex_is_branch;
    logic [31:0]      ex_pc;
    logic             ex_taken;
    logic [31:0]      ex_target;
    logic             ex_pred_taken;
    logic [31:0]      ex_pred_target;
    logic             mispredict;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    branch_predictor #(.IDX_BITS(IDX_BITS), .TAG_BITS(TAG_BITS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int            n_vec = 0;
    int            n_err = 0;
    logic [W-1:0]  exp_q[$];
    string         name_q[$];

    typedef struct {
        string        name;
        logic         r, v, br, tk, ptk;
        logic [31:0]  ifpc, expc, tgt, ptgt;
        logic [W-1:0] exp;
    } step_t;

    // Reference table model, advanced at every rising edge.
    logic             m_valid [DEPTH];
    logic [TAG_BITS-1:0] m_tag [DEPTH];
    int               m_ctr   [DEPTH];
    logic [31:0]      m_tgt   [DEPTH];
    logic [CNT_W-1:0] m_bc, m_mc;

    function automatic logic [W-1:0] pack(input logic pt, input logic [31:0] ptg,
                                          input logic mp, input logic [31:0] rpc,
                                          input logic [CNT_W-1:0] bc,
                                          input logic [CNT_W-1:0] mc);
        return {pt, ptg, mp, rpc, bc, mc};
    endfunction

    // redirect_pc is only meaningful while an EX branch is present.
    function automatic logic [W-1:0] observe();
        logic u;
        u = ex_valid && ex_is_branch;
        return pack(pred_taken, pred_target, mispredict, u ? redirect_pc : 32'h0,
                    branch_cnt, mispred_cnt);
    endfunction

    function automatic step_t mk(input string nm, input logic r, input logic v,
                                 input logic br, input logic [31:0] ifpc,
                                 input logic [31:0] expc, input logic tk,
                                 input logic [31:0] tgt, input logic ptk,
                                 input logic [31:0] ptgt, input logic [W-1:0] e);
        step_t s;
        s.name = nm; s.r = r; s.v = v; s.br = br; s.ifpc = ifpc; s.expc = expc;
        s.tk = tk; s.tgt = tgt; s.ptk = ptk; s.ptgt = ptgt; s.exp = e;
        return s;
    endfunction

    function automatic logic [32:0] m_lookup(input logic [31:0] pc);
        int   idx;
        logic hit;
        idx = int'(pc[IDX_BITS+1:2]);
        hit = m_valid[idx] && (m_tag[idx] == pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]);
        return {hit && (m_ctr[idx] >= 2), hit ? m_tgt[idx] : 32'h0};
    endfunction

    task automatic model_step();
        int   idx;
        logic hit, mp;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 1;
            end
            m_bc = '0;
            m_mc = '0;
        end else if (ex_valid && ex_is_branch) begin
            idx = int'(ex_pc[IDX_BITS+1:2]);
            hit = m_valid[idx] && (m_tag[idx] == ex_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]);
            mp  = (ex_taken != ex_pred_taken) || (ex_taken && ex_pred_target != ex_target);
            if (ex_taken) begin
                if (hit) begin
                    if (m_ctr[idx] < 3) m_ctr[idx] = m_ctr[idx] + 1;
                end else begin
                    m_valid[idx] = 1'b1;
                    m_tag[idx]   = ex_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
                    m_ctr[idx]   = 2;
                end
                m_tgt[idx] = ex_target;
            end else if (hit && m_ctr[idx] > 0) begin
                m_ctr[idx] = m_ctr[idx] - 1;
            end
            if (m_bc != '1) m_bc = m_bc + 1'b1;
            if (mp && m_mc != '1) m_mc = m_mc + 1'b1;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply(input step_t s);
        rst = s.r; ex_valid = s.v; ex_is_branch = s.br; if_pc = s.ifpc;
        ex_pc = s.expc; ex_taken = s.tk; ex_target = s.tgt;
        ex_pred_taken = s.ptk; ex_pred_target = s.ptgt;
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        step_t        s[$];
        logic [W-1:0] got, exp;
        string        nm;
        rst = 1'b1; ex_valid = 1'b0; ex_is_branch = 1'b0; if_pc = 32'h100;
        tick(); tick();
        s.push_back(mk("reset_lookup", 0, 0, 0, 32'h100, 0, 0, 0, 0, 0, pack(0, 0, 0, 0, 0, 0)));
        s.push_back(mk("reset_nonbranch", 0, 1, 0, 32'h100, 32'h100, 1, 32'h80, 0, 0,
                       pack(0, 0, 0, 0, 0, 0)));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            exp_q.push_back(s[i].exp); name_q.push_back(s[i].name);
            @(negedge clk);
            got = observe(); exp = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", nm, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_train();
        step_t        s[$];
        logic [W-1:0] got, exp;
        string        nm;
        s.push_back(mk("first_taken", 0, 1, 1, 32'h100, 32'h100, 1, 32'h80, 0, 0,
                       pack(0, 0, 1, 32'h80, 0, 0)));
        s.push_back(mk("trained_lookup", 0, 0, 0, 32'h100, 0, 0, 0, 0, 0,
                       pack(1, 32'h80, 0, 0, 1, 1)));
        for (int k = 0; k < 4; k++)
            s.push_back(mk($sformatf("taken_%0d", k), 0, 1, 1, 32'h100, 32'h100, 1, 32'h80,
                           1, 32'h80, pack(1, 32'h80, 0, 32'h80, 32'(1 + k), 1)));
        s.push_back(mk("not_taken_0", 0, 1, 1, 32'h100, 32'h100, 0, 32'h80, 1, 32'h80,
                       pack(1, 32'h80, 1, 32'h104, 5, 1)));
        s.push_back(mk("not_taken_1", 0, 1, 1, 32'h100, 32'h100, 0, 32'h80, 1, 32'h80,
                       pack(1, 32'h80, 1, 32'h104, 6, 2)));
        s.push_back(mk("weak_not_taken", 0, 0, 0, 32'h100, 0, 0, 0, 0, 0,
                       pack(0, 32'h80, 0, 0, 7, 3)));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            exp_q.push_back(s[i].exp); name_q.push_back(s[i].name);
            @(negedge clk);
            got = observe(); exp = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", nm, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_alias();
        step_t        s[$];
        logic [W-1:0] got, exp;
        string        nm;
        logic [31:0]  alias_pc;
        alias_pc = 32'h100 + (32'd4 << IDX_BITS);
        s.push_back(mk("alias_replace", 0, 1, 1, 32'h100, alias_pc, 1, 32'h300, 0, 0,
                       pack(0, 32'h80, 1, 32'h300, 7, 3)));
        s.push_back(mk("alias_orig_miss", 0, 0, 0, 32'h100, 0, 0, 0, 0, 0,
                       pack(0, 0, 0, 0, 8, 4)));
        s.push_back(mk("alias_new_hit", 0, 0, 0, alias_pc, 0, 0, 0, 0, 0,
                       pack(1, 32'h300, 0, 0, 8, 4)));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            exp_q.push_back(s[i].exp); name_q.push_back(s[i].name);
            @(negedge clk);
            got = observe(); exp = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", nm, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_same_cycle();
        step_t        s[$];
        logic [W-1:0] got, exp;
        string        nm;
        s.push_back(mk("pre_reset", 1, 0, 0, 32'h100, 0, 0, 0, 0, 0, pack(0, 0, 0, 0, 8, 4)));
        s.push_back(mk("same_cycle_lookup", 0, 1, 1, 32'h200, 32'h200, 1, 32'h240, 0, 0,
                       pack(0, 0, 1, 32'h240, 0, 0)));
        s.push_back(mk("next_cycle_lookup", 0, 0, 0, 32'h200, 0, 0, 0, 0, 0,
                       pack(1, 32'h240, 0, 0, 1, 1)));
        s.push_back(mk("rst_with_upd", 1, 1, 1, 32'h200, 32'h300, 1, 32'h500, 0, 0,
                       pack(1, 32'h240, 1, 32'h500, 1, 1)));
        s.push_back(mk("after_rst_200", 0, 0, 0, 32'h200, 0, 0, 0, 0, 0, pack(0, 0, 0, 0, 0, 0)));
        s.push_back(mk("after_rst_300", 0, 0, 0, 32'h300, 0, 0, 0, 0, 0, pack(0, 0, 0, 0, 0, 0)));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            exp_q.push_back(s[i].exp); name_q.push_back(s[i].name);
            @(negedge clk);
            got = observe(); exp = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", nm, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_no_update();
        step_t        s[$];
        logic [W-1:0] got, exp;
        string        nm;
        s.push_back(mk("bubble_branch", 0, 0, 1, 32'h200, 32'h200, 1, 32'h400, 0, 0,
                       pack(0, 0, 0, 0, 0, 0)));
        s.push_back(mk("valid_nonbranch", 0, 1, 0, 32'h200, 32'h200, 1, 32'h400, 0, 0,
                       pack(0, 0, 0, 0, 0, 0)));
        s.push_back(mk("no_change_200", 0, 0, 0, 32'h200, 0, 0, 0, 0, 0, pack(0, 0, 0, 0, 0, 0)));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            exp_q.push_back(s[i].exp); name_q.push_back(s[i].name);
            @(negedge clk);
            got = observe(); exp = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", nm, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0]  pool[6];
        logic [32:0]  lk, elk;
        logic [W-1:0] got, exp;
        logic         u, mp;
        logic [31:0]  rd;
        pool = '{32'h100, 32'h104, 32'h200, 32'h4100, 32'h4104, 32'h3c0};
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            ex_valid     = ($urandom_range(0, 9) < 8);
            ex_is_branch = ($urandom_range(0, 9) < 8);
            ex_pc        = pool[$urandom_range(0, 5)];
            if_pc        = pool[$urandom_range(0, 5)];
            ex_taken     = $urandom_range(0, 1);
            ex_target    = {$urandom_range(0, 255), 2'b00} + 32'h1000;
            elk          = m_lookup(ex_pc);
            if ($urandom_range(0, 1) == 1) begin
                ex_pred_taken  = elk[32];
                ex_pred_target = elk[31:0];
            end else begin
                ex_pred_taken  = $urandom_range(0, 1);
                ex_pred_target = {$urandom_range(0, 255), 2'b00} + 32'h1000;
            end
            lk = m_lookup(if_pc);
            u  = ex_valid && ex_is_branch;
            mp = u && ((ex_taken != ex_pred_taken) ||
                       (ex_taken && ex_pred_target != ex_target));
            rd = u ? (ex_taken ? ex_target : ex_pc + 32'd4) : 32'h0;
            exp_q.push_back(pack(lk[32], lk[31:0], mp, rd, m_bc, m_mc));
            name_q.push_back($sformatf("random_%0d", i));
            @(negedge clk);
            got = observe(); exp = exp_q.pop_front(); n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", name_q.pop_front(), got, exp);
            end else begin
                void'(name_q.pop_front());
            end
            tick();
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        rst = 1'b1; if_pc = '0; ex_valid = 1'b0; ex_is_branch = 1'b0; ex_pc = '0;
        ex_taken = 1'b0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
        test_reset();
        test_train();
        test_alias();
        test_same_cycle();
        test_no_update();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
